// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file: dump FSM encoding,
// default geometry and the first-dumped-register helper.
package rf_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDump = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // r0 carries no information when hardwired, so the dump skips it.
    function automatic int unsigned dump_first(input int unsigned zero_reg);
        return (zero_reg != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/rf_dump_fsm.sv
// Halt-triggered register dump sequencer: edge detect, state, address counter
// and valid/done generation. Runs once per reset.
module rf_dump_fsm
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic              dump_done,
    output logic [ADDR_W-1:0] dump_addr
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(dump_first(ZERO_REG));
    localparam logic [ADDR_W-1:0] LAST  = '1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hlt_q;
    logic              start;

    assign start = hlt & ~hlt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDump;
                    addr_d  = FIRST;
                end
            end
            StDump: begin
                if (dump_ready) begin
                    if (addr_q == LAST) begin
                        state_d = StDone;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hlt_q   <= hlt;
        end
    end

    assign dump_valid = (state_q == StDump);
    assign dump_done  = (state_q == StDone);
    assign dump_addr  = addr_q;

endmodule

// File: rtl/rf_param.sv
// Parametrised multi-read-port register file with optional write-to-read
// bypass, hardwired zero register and a halt-triggered dump port.
module rf_param
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     hlt,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;

    assign wr_en = we & ~((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rd_q, rd_d;

        assign raddr = rd_addr[i*ADDR_W +: ADDR_W];

        // Zero check comes first so a suppressed r0 write never leaks through bypass.
        always_comb begin
            rd_d = rd_q;
            if (re[i]) begin
                if ((ZERO_REG != 0) && (raddr == '0)) begin
                    rd_d = '0;
                end else if ((BYPASS != 0) && wr_en && (wr_addr == raddr)) begin
                    rd_d = wr_data;
                end else begin
                    rd_d = mem_q[raddr];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rd_q;
    end

    rf_dump_fsm #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_dump_fsm (
        .clk        (clk),
        .rst        (rst),
        .hlt        (hlt),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_done  (dump_done),
        .dump_addr  (dump_addr)
    );

    // Combinational so the beat reflects any write already committed.
    assign dump_data = mem_q[dump_addr];

endmodule

// File: tb/tb_rf_param.sv
// Scoreboard bench for rf_param: expected reads and dump beats are queued by
// the stimulus and popped by a negedge monitor.
module tb_rf_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  re = '0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data, nb_rd_data;
    logic        we = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        hlt = 1'b0;
    logic        dump_ready = 1'b0;
    logic        dump_valid, nb_dump_valid;
    logic [3:0]  dump_addr, nb_dump_addr;
    logic [15:0] dump_data, nb_dump_data;
    logic        dump_done, nb_dump_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] q0[$], q1[$], qnb[$];
    logic [19:0] qd[$];
    logic [1:0]  re_q = '0;

    always #5 clk = ~clk;

    rf_param u_dut (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .hlt        (hlt),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    rf_param #(.BYPASS(0)) u_dut_nb (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .rd_addr    (rd_addr),
        .rd_data    (nb_rd_data),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .hlt        (hlt),
        .dump_valid (nb_dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (nb_dump_addr),
        .dump_data  (nb_dump_data),
        .dump_done  (nb_dump_done)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    always @(posedge clk) re_q <= re;

    // Monitor: a read result is due the negedge after re was sampled.
    always @(negedge clk) begin
        if (re_q[0]) begin
            if (q0.size() == 0) chk("rd0_unexpected", 32'd1, 32'd0);
            else chk("rd0", {16'h0, rd_data[15:0]}, {16'h0, q0.pop_front()});
        end
        if (re_q[1]) begin
            if (q1.size() == 0) chk("rd1_unexpected", 32'd1, 32'd0);
            else chk("rd1", {16'h0, rd_data[31:16]}, {16'h0, q1.pop_front()});
            if (qnb.size() == 0) chk("rd1_nb_unexpected", 32'd1, 32'd0);
            else chk("rd1_nobypass", {16'h0, nb_rd_data[31:16]}, {16'h0, qnb.pop_front()});
        end
        if (dump_valid && dump_ready) begin
            if (qd.size() == 0) chk("dump_unexpected_beat", {12'h0, dump_addr, dump_data}, 32'hFFFF_FFFF);
            else chk("dump_beat", {12'h0, dump_addr, dump_data}, {12'h0, qd.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic pulse_hlt();
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
    endtask

    task automatic run_dump(input string name);
        int n = 0;
        dump_ready = 1'b1;
        while (!dump_done && n < 100) begin
            tick();
            dump_ready = ~dump_ready;
            n++;
        end
        if (!dump_done) chk({name, "_timeout"}, 32'd0, 32'd1);
        dump_ready = 1'b0;
        @(negedge clk);
        chk({name, "_queue_drained"}, qd.size(), 0);
        chk({name, "_done"}, {30'h0, dump_done, dump_valid}, 32'h2);
        #1;
    endtask

    initial begin
        // Reset clears r5 written beforehand.
        tick();
        rst = 1'b0;
        wr(4'd5, 16'hBEEF);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_dump_flags", {30'h0, dump_valid, dump_done}, 32'h0);
        #1;
        re = 2'b01; rd_addr = 8'h05; q0.push_back(16'h0000);
        tick();
        re = 2'b00;

        // Basic write then read, then hold with re low.
        wr(4'd3, 16'h1234);
        re = 2'b01; rd_addr = 8'h03; q0.push_back(16'h1234);
        tick();
        re = 2'b00; rd_addr = 8'h09;
        tick();
        @(negedge clk);
        chk("rd0_hold", {16'h0, rd_data[15:0]}, 32'h1234);
        #1;

        // Bypass: new value with BYPASS=1, old value with BYPASS=0.
        wr(4'd7, 16'h0001);
        we = 1'b1; wr_addr = 4'd7; wr_data = 16'hA5A5;
        re = 2'b10; rd_addr = 8'h70;
        q1.push_back(16'hA5A5); qnb.push_back(16'h0001);
        tick();
        we = 1'b0;
        re = 2'b11; rd_addr = 8'h77;
        q0.push_back(16'hA5A5); q1.push_back(16'hA5A5); qnb.push_back(16'hA5A5);
        tick();

        // Zero register under a simultaneous write, and afterwards.
        we = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        re = 2'b11; rd_addr = 8'h00;
        q0.push_back(16'h0); q1.push_back(16'h0); qnb.push_back(16'h0);
        tick();
        we = 1'b0; re = 2'b01;
        q0.push_back(16'h0);
        tick();
        re = 2'b00;

        // Full dump with alternating backpressure.
        for (int n = 1; n < 16; n++) wr(4'(n), 16'(n * 16'h0101));
        for (int n = 1; n < 16; n++) qd.push_back({4'(n), 16'(n * 16'h0101)});
        pulse_hlt();
        run_dump("dump1");
        chk("nb_dump_done", {31'h0, nb_dump_done}, 32'h1);

        // Second halt after completion produces no beats.
        dump_ready = 1'b1;
        pulse_hlt();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("no_redump_valid", {31'h0, dump_valid}, 32'h0);
            #1;
        end
        dump_ready = 1'b0;

        // Reset mid-dump, then restart from addr 1 with cleared registers.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 1; n < 16; n++) wr(4'(n), 16'(n * 16'h0101));
        pulse_hlt();
        for (int n = 1; n < 6; n++) qd.push_back({4'(n), 16'(n * 16'h0101)});
        dump_ready = 1'b1;
        repeat (5) tick();
        dump_ready = 1'b0;
        @(negedge clk);
        chk("mid_dump_addr", {12'h0, dump_addr, dump_data}, {12'h0, 4'd6, 16'h0606});
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_flags", {30'h0, dump_valid, dump_done}, 32'h0);
        #1;
        re = 2'b11; rd_addr = 8'hF6;
        q0.push_back(16'h0); q1.push_back(16'h0); qnb.push_back(16'h0);
        tick();
        re = 2'b00;
        for (int n = 1; n < 16; n++) qd.push_back({4'(n), 16'h0000});
        pulse_hlt();
        run_dump("dump2");

        tick();
        chk("rd_queues_drained", q0.size() + q1.size() + qnb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised, fully synchronous multi-read-port register file for the pipelined CPU datapath.
- Generalises the single-cycle triple-ported file in three ways:
  - configurable data width, depth and read-port count
  - optional write-to-read bypass
  - hardware register dump engine triggered by halt
- Sits between decode (read ports) and writeback (write port). The dump port feeds the testbench/debug monitor.

Parameters:
- DATA_W, 16, register data width in bits
- ADDR_W, 4, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 means register 0 is hardwired to zero
- BYPASS, 1, 1 means a same-cycle write is forwarded to a matching read

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- re  input  NUM_RD  per-port read enable
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed registered read data
- we  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- hlt  input  1  halt; a rising edge starts a dump
- dump_valid  output  1  dump_addr/dump_data are valid
- dump_ready  input  1  consumer accepts the current dump beat
- dump_addr  output  ADDR_W  register index being dumped
- dump_data  output  DATA_W  contents of that register
- dump_done  output  1  dump complete; sticky until rst

Behaviour:
- Clock/reset: one clock (clk). rst is synchronous and active-high.
- Reset: on the rst edge, all registers become 0, rd_data 0, dump_valid 0, dump_done 0, dump_addr 0, FSM IDLE, hlt_q 0. rst has priority over every other input.
- Write:
  - at the rising edge, mem[wr_addr] <= wr_data when we=1.
  - The write is suppressed when ZERO_REG=1 and wr_addr=0.
- Read:
  - latency 1. At the rising edge with re[i]=1, rd_data[i] <= mem[rd_addr[i]].
  - With re[i]=0, rd_data[i] holds its previous value.
- Bypass (BYPASS=1): if re[i] & we & (wr_addr==rd_addr[i]) and the write is not suppressed, rd_data[i] <= wr_data (the new value). With BYPASS=0, the read returns the old value.
- Zero register (ZERO_REG=1): a read of address 0 always returns 0, including under bypass.
- Multiple read ports may address the same register in the same cycle; each returns identical data.
- Dump FSM states: IDLE, DUMP, DONE.
  - hlt_q registers hlt every cycle. Start condition: hlt & ~hlt_q.
  - IDLE -> DUMP on the start condition. dump_addr loads FIRST (1 if ZERO_REG else 0).
  - DUMP: dump_valid=1; dump_data = mem[dump_addr] combinationally, so it reflects writes already committed.
  - Beat transfer: dump_valid & dump_ready. On a transfer with dump_addr = 2**ADDR_W-1, go to DONE; otherwise dump_addr increments. Without dump_ready, addr and data hold (data may change if that register is written).
  - DONE: dump_valid=0, dump_done=1. Further hlt edges are ignored until rst.
  - A hlt edge while in DUMP is ignored.
  - rst in any state -> IDLE.
- Normal read and write ports stay fully functional during the dump.

Decomposition:
- Shared package rf_pkg holds:
  - dump state encoding: IDLE=2'd0, DUMP=2'd1, DONE=2'd2
  - default localparams for DATA_W/ADDR_W
  - a function computing FIRST from ZERO_REG
- One sub-module, rf_dump_fsm, contains the hlt edge detect, state register, dump_addr counter and valid/done generation. It drives dump_addr into the memory read mux in rf_param.
- Storage, write logic and the read/bypass generate loop remain in rf_param.

Test Plan:
- Reset: rst=1 for 2 cycles after writing 0xBEEF to r5; read r5 -> rd_data=0x0000; dump_valid=0, dump_done=0.
- Write/read: write r3=0x1234; next cycle re[0]=1, rd_addr[0]=3 -> rd_data[0]=0x1234 one cycle later. Then re[0]=0 with rd_addr changed -> rd_data[0] holds 0x1234.
- Bypass: r7=0x0001; same cycle we=1, wr_addr=7, wr_data=0xA5A5, re[1]=1, rd_addr[1]=7 -> rd_data[1]=0xA5A5 (BYPASS=1); with BYPASS=0 build -> 0x0001.
- Zero register: we=1, wr_addr=0, wr_data=0xFFFF, port 0 reading r0 in the same cycle -> rd_data[0]=0; later read of r0 -> 0.
- Dump with backpressure:
  - Setup: load rN=N*0x0101; pulse hlt; dump_ready toggles 1,0,1,...
  - Beats observed: addr 1..15, data 0x0101..0x0F0F in order, no skips or duplicates.
  - Completion: dump_done=1 after the addr 15 transfer. A second hlt pulse produces no beats.
- Reset mid-dump: assert rst while dump_addr=6 -> next cycle dump_valid=0, state IDLE, all registers 0. A new hlt edge restarts the dump at addr 1 with data 0.
